// File: rtl/irq_pkg.sv
// Shared types and constants for the four-channel interrupt controller.
package irq_pkg;

  localparam int unsigned IRQ_NCH = 4;
  localparam int unsigned IRQ_IDW = 2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc4.sv
// Combinational 4-to-2 priority encoder; bit 3 has highest priority.
module irq_prio_enc4
  import irq_pkg::*;
(
  input  logic [IRQ_NCH-1:0] req_i,
  output logic [IRQ_IDW-1:0] idx_o,
  output logic               valid_o
);

  always_comb begin
    idx_o   = 2'd0;
    valid_o = 1'b1;
    if (req_i[3]) begin
      idx_o = 2'd3;
    end else if (req_i[2]) begin
      idx_o = 2'd2;
    end else if (req_i[1]) begin
      idx_o = 2'd1;
    end else if (req_i[0]) begin
      idx_o = 2'd0;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl_4ch.sv
// Four-channel edge-capturing interrupt controller with req/ack issue and post-ack holdoff.
// Define IRQ_CTRL_SYNC_EN to pass irq_in through a 2-flop synchronizer first.
module irq_ctrl_4ch
  import irq_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   irq_in,
  input  logic [3:0]   mask,
  input  logic         ack,
  input  logic         clr_lost,
  output logic         irq_req,
  output logic [1:0]   irq_id,
  output logic [3:0]   pending,
  output logic [3:0]   irq_lost
);

  localparam logic [3:0] HoldLoad = 4'(HOLDOFF_CYC - 1);

  logic [3:0] irq_s;
  logic [3:0] irq_prev_q;
  logic [3:0] rise;
  logic [3:0] ack_clr;
  logic [3:0] pending_q, pending_d;
  logic [3:0] lost_q, lost_d;
  logic       req_q, req_d;
  logic [1:0] id_q, id_d;
  logic [3:0] cnt_q, cnt_d;
  irq_state_e state_q, state_d;
  logic [1:0] enc_idx;
  logic       enc_vld;

`ifdef IRQ_CTRL_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  irq_prio_enc4 u_enc (
    .req_i   (pending_q & ~mask),
    .idx_o   (enc_idx),
    .valid_o (enc_vld)
  );

  always_comb begin
    rise    = irq_s & ~irq_prev_q;
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    ack_clr = '0;

    unique case (state_q)
      StIdle: begin
        if (enc_vld) begin
          id_d    = enc_idx;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        // Mask is not consulted here: the presented id stays frozen until ack.
        if (ack) begin
          ack_clr = 4'b0001 << id_q;
          req_d   = 1'b0;
          if (HOLDOFF_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new edge beats a same-cycle ack clear and is then not counted as lost.
    pending_d = (pending_q & ~ack_clr) | rise;
    lost_d    = (clr_lost ? 4'b0000 : lost_q) | (rise & pending_q & ~ack_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      lost_q     <= '0;
      req_q      <= 1'b0;
      id_q       <= '0;
      cnt_q      <= '0;
      state_q    <= StIdle;
    end else begin
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      lost_q     <= lost_d;
      req_q      <= req_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  assign irq_req  = req_q;
  assign irq_id   = id_q;
  assign pending  = pending_q;
  assign irq_lost = lost_q;

endmodule

// File: tb/tb_irq_ctrl_4ch.sv
// Scoreboard bench for irq_ctrl_4ch: expected ids queued at stimulus, checked at issue.
module tb_irq_ctrl_4ch;

  localparam int unsigned HOLD = 1;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT = 2 + SD;

  logic       clk = 1'b0;
  logic       rst, ack, clr_lost;
  logic [3:0] irq_in, mask;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] pending, irq_lost;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  irq_ctrl_4ch #(.HOLDOFF_CYC(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .mask     (mask),
    .ack      (ack),
    .clr_lost (clr_lost),
    .irq_req  (irq_req),
    .irq_id   (irq_id),
    .pending  (pending),
    .irq_lost (irq_lost)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!irq_req && n < 40) begin
      tick();
      n++;
    end
    if (!irq_req) n = -1;
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return 99;
    return exp_q.pop_front();
  endfunction

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b0; clr_lost = 1'b0; irq_in = '0; mask = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", irq_req); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("FAIL rst_id got %0d want 0", irq_id); end
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rst_pend got %b want 0000", pending); end
    n_cmp++; if (irq_lost !== 4'b0000) begin n_err++; $display("FAIL rst_lost got %b want 0000", irq_lost); end
  endtask

  task automatic test_single();
    int n, e;
    irq_in = 4'b0100;
    exp_q.push_back(2);
    tick();
    irq_in = '0;
    wait_req(n);
    n_cmp++; if (n < 0 || n + 1 != LAT) begin n_err++; $display("FAIL single_lat got %0d want %0d", n + 1, LAT); end
    e = pop_exp();
    n_cmp++; if (int'(irq_id) != e) begin n_err++; $display("FAIL single_id got %0d want %0d", irq_id, e); end
    n_cmp++; if (pending !== 4'b0100) begin n_err++; $display("FAIL single_pend got %b want 0100", pending); end
    do_ack();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL single_ackreq got %b want 0", irq_req); end
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL single_ackpend got %b want 0000", pending); end
    tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL single_hold got %b want 0", irq_req); end
    repeat (3) tick();
  endtask

  task automatic test_prio();
    int n, e;
    irq_in = 4'b1001;
    exp_q.push_back(3);
    exp_q.push_back(0);
    tick();
    irq_in = '0;
    wait_req(n);
    e = pop_exp();
    n_cmp++; if (n < 0 || int'(irq_id) != e) begin n_err++; $display("FAIL prio_first got %0d want %0d", irq_id, e); end
    do_ack();
    wait_req(n);
    n_cmp++; if (n != int'(HOLD) + 1) begin n_err++; $display("FAIL prio_holdoff got %0d want %0d", n, HOLD + 1); end
    e = pop_exp();
    n_cmp++; if (int'(irq_id) != e) begin n_err++; $display("FAIL prio_second got %0d want %0d", irq_id, e); end
    do_ack();
    repeat (3) tick();
  endtask

  task automatic test_mask();
    int n, e;
    mask = 4'b1000;
    irq_in = 4'b1010;
    exp_q.push_back(1);
    tick();
    irq_in = '0;
    wait_req(n);
    e = pop_exp();
    n_cmp++; if (n < 0 || int'(irq_id) != e) begin n_err++; $display("FAIL mask_first got %0d want %0d", irq_id, e); end
    mask = 4'b0000;
    tick(); tick();
    n_cmp++; if (irq_req !== 1'b1 || irq_id !== 2'd1) begin
      n_err++; $display("FAIL mask_frozen got req=%b id=%0d want req=1 id=1", irq_req, irq_id);
    end
    exp_q.push_back(3);
    do_ack();
    wait_req(n);
    e = pop_exp();
    n_cmp++; if (n < 0 || int'(irq_id) != e) begin n_err++; $display("FAIL mask_second got %0d want %0d", irq_id, e); end
    do_ack();
    repeat (3) tick();
  endtask

  task automatic test_lost();
    int n, e;
    irq_in = 4'b0100;
    exp_q.push_back(2);
    tick();
    irq_in = '0;
    repeat (SD + 2) tick();
    n_cmp++; if (irq_lost !== 4'b0000) begin n_err++; $display("FAIL lost_pre got %b want 0000", irq_lost); end
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    repeat (SD + 1) tick();
    n_cmp++; if (irq_lost !== 4'b0100) begin n_err++; $display("FAIL lost_set got %b want 0100", irq_lost); end
    clr_lost = 1'b1;
    tick();
    clr_lost = 1'b0;
    n_cmp++; if (irq_lost !== 4'b0000) begin n_err++; $display("FAIL lost_clr got %b want 0000", irq_lost); end
    wait_req(n);
    e = pop_exp();
    n_cmp++; if (n < 0 || int'(irq_id) != e) begin n_err++; $display("FAIL lost_id got %0d want %0d", irq_id, e); end
    do_ack();
    repeat (3) tick();
  endtask

  task automatic test_ack_edge();
    int n, e;
    irq_in = 4'b0010;
    exp_q.push_back(1);
    tick();
    irq_in = '0;
    wait_req(n);
    e = pop_exp();
    n_cmp++; if (n < 0 || int'(irq_id) != e) begin n_err++; $display("FAIL ackedge_first got %0d want %0d", irq_id, e); end
    tick();
    // Line rises so its edge is detected on the same clock edge that samples ack.
    irq_in = 4'b0010;
    repeat (SD) tick();
    exp_q.push_back(1);
    do_ack();
    irq_in = '0;
    n_cmp++; if (pending[1] !== 1'b1) begin n_err++; $display("FAIL ackedge_pend got %b want 1", pending[1]); end
    n_cmp++; if (irq_lost[1] !== 1'b0) begin n_err++; $display("FAIL ackedge_lost got %b want 0", irq_lost[1]); end
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL ackedge_req got %b want 0", irq_req); end
    wait_req(n);
    n_cmp++; if (n != int'(HOLD) + 1) begin n_err++; $display("FAIL ackedge_reissue got %0d want %0d", n, HOLD + 1); end
    e = pop_exp();
    n_cmp++; if (int'(irq_id) != e) begin n_err++; $display("FAIL ackedge_id got %0d want %0d", irq_id, e); end
    do_ack();
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL ackedge_final got %b want 0000", pending); end
    repeat (3) tick();
  endtask

  task automatic test_rst_mid();
    int n, e;
    irq_in = 4'b0001;
    exp_q.push_back(0);
    tick();
    irq_in = 4'b0000;
    wait_req(n);
    e = pop_exp();
    n_cmp++; if (n < 0 || int'(irq_id) != e) begin n_err++; $display("FAIL rstmid_id got %0d want %0d", irq_id, e); end
    irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL rstmid_req got %b want 0", irq_req); end
    n_cmp++; if (pending !== 4'b0000) begin n_err++; $display("FAIL rstmid_pend got %b want 0000", pending); end
    repeat (SD + 3) tick();
    n_cmp++; if (irq_req !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet got %b want 0", irq_req); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prio();
    test_mask();
    test_lost();
    test_ack_edge();
    test_rst_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_drain got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
